// File: rtl/hazard_ctrl.sv
// hazard_ctrl: stall/flush sequencing for the five-stage RV32I pipeline.
// Detects load-use hazards (one-cycle bubble), taken branches/jumps (flush
// of the two wrong-path slots) and data-memory waits (full freeze). Keeps
// saturating stall/flush statistics and a sticky memory-timeout flag.
//
// Ports:
//   clk, reset_n           clock, asynchronous active-low reset
//   Rs1D, Rs2D             source registers of the instruction in ID
//   RdE, MemReadE          destination / load flag of the instruction in EX
//   PCSrcE                 branch/jump taken, resolved in EX
//   MemReqM, MemReadyM     data-memory access in MEM and its completion
//   StallF/D/E/M           hold PC, IF/ID, ID/EX, EX/MEM (combinational)
//   FlushD, ClearE         clear IF/ID, clear ID/EX (combinational)
//   CtrlState              RUN=0, LOAD_BUBBLE=1, MEM_WAIT=2
//   StallCount, FlushCount saturating statistics
//   MemErr                 sticky: a memory wait reached TIMEOUT
module hazard_ctrl #(
   parameter int unsigned REG_W   = 5,
   parameter int unsigned CNT_W   = 16,
   parameter int unsigned TIMEOUT = 255
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic [REG_W-1:0] Rs1D,
   input  logic [REG_W-1:0] Rs2D,
   input  logic [REG_W-1:0] RdE,
   input  logic             MemReadE,
   input  logic             PCSrcE,
   input  logic             MemReqM,
   input  logic             MemReadyM,
   output logic             StallF,
   output logic             StallD,
   output logic             StallE,
   output logic             StallM,
   output logic             FlushD,
   output logic             ClearE,
   output logic [1:0]       CtrlState,
   output logic [CNT_W-1:0] StallCount,
   output logic [CNT_W-1:0] FlushCount,
   output logic             MemErr
);

   localparam logic [1:0] ST_RUN    = 2'd0;
   localparam logic [1:0] ST_BUBBLE = 2'd1;
   localparam logic [1:0] ST_WAIT   = 2'd2;

   localparam logic [CNT_W-1:0] CNT_MAX   = '1;
   localparam logic [CNT_W-1:0] TIMEOUT_C = CNT_W'(TIMEOUT);

   logic [1:0]       state_q;
   logic [1:0]       state_d;
   logic             mem_wait;
   logic             load_use;
   logic [CNT_W-1:0] wait_cnt_q;
   logic [CNT_W-1:0] wait_cnt_inc;

   assign mem_wait = MemReqM & ~MemReadyM;

   // The bubble already sits in EX during LOAD_BUBBLE, so the hazard is masked.
   assign load_use = MemReadE & (RdE != '0) & ((RdE == Rs1D) | (RdE == Rs2D))
                   & (state_q != ST_BUBBLE);

   assign CtrlState    = state_q;
   assign wait_cnt_inc = wait_cnt_q + CNT_W'(1);

   // State register.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) state_q <= ST_RUN;
      else          state_q <= state_d;
   end

   // Mealy outputs and next state share one priority chain:
   // memory wait > taken branch > load-use > idle.
   always_comb begin
      state_d = ST_RUN;
      StallF  = 1'b0;
      StallD  = 1'b0;
      StallE  = 1'b0;
      StallM  = 1'b0;
      FlushD  = 1'b0;
      ClearE  = 1'b0;
      if (mem_wait) begin
         StallF  = 1'b1;
         StallD  = 1'b1;
         StallE  = 1'b1;
         StallM  = 1'b1;
         state_d = ST_WAIT;
      end else if (PCSrcE) begin
         FlushD  = 1'b1;
         ClearE  = 1'b1;
      end else if (load_use) begin
         StallF  = 1'b1;
         StallD  = 1'b1;
         ClearE  = 1'b1;
         state_d = ST_BUBBLE;
      end
   end

   // Consecutive memory-wait length; holds at TIMEOUT so it cannot wrap.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         wait_cnt_q <= '0;
         MemErr     <= 1'b0;
      end else if (mem_wait) begin
         if (wait_cnt_q != TIMEOUT_C) wait_cnt_q <= wait_cnt_inc;
         if (wait_cnt_inc == TIMEOUT_C) MemErr <= 1'b1;
      end else begin
         wait_cnt_q <= '0;
      end
   end

   // Saturating statistics.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         StallCount <= '0;
         FlushCount <= '0;
      end else begin
         if (StallF && (StallCount != CNT_MAX)) StallCount <= StallCount + CNT_W'(1);
         if (FlushD && (FlushCount != CNT_MAX)) FlushCount <= FlushCount + CNT_W'(1);
      end
   end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl: directed scenarios followed by
// randomized traffic, all compared against a cycle-level reference model.
module tb_hazard_ctrl;

   localparam int unsigned REG_W   = 5;
   localparam int unsigned CNT_W   = 6;
   localparam int unsigned TIMEOUT = 4;
   localparam int          SAT     = (1 << CNT_W) - 1;

   logic             clk = 1'b0;
   logic             reset_n;
   logic [REG_W-1:0] Rs1D, Rs2D, RdE;
   logic             MemReadE, PCSrcE, MemReqM, MemReadyM;
   logic             StallF, StallD, StallE, StallM, FlushD, ClearE;
   logic [1:0]       CtrlState;
   logic [CNT_W-1:0] StallCount, FlushCount;
   logic             MemErr;

   int checks   = 0;
   int failures = 0;

   // Reference model state
   int m_bubble;     // previous cycle issued a load-use stall
   int m_waiting;    // previous cycle was a memory wait
   int m_stall_cnt;
   int m_flush_cnt;
   int m_run;        // consecutive memory-wait cycles
   int m_err;

   hazard_ctrl #(.REG_W(REG_W), .CNT_W(CNT_W), .TIMEOUT(TIMEOUT)) dut (
      .clk(clk), .reset_n(reset_n),
      .Rs1D(Rs1D), .Rs2D(Rs2D), .RdE(RdE), .MemReadE(MemReadE),
      .PCSrcE(PCSrcE), .MemReqM(MemReqM), .MemReadyM(MemReadyM),
      .StallF(StallF), .StallD(StallD), .StallE(StallE), .StallM(StallM),
      .FlushD(FlushD), .ClearE(ClearE), .CtrlState(CtrlState),
      .StallCount(StallCount), .FlushCount(FlushCount), .MemErr(MemErr)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0d expected=%0d (t=%0t)", tag, got, exp, $time);
      end
   endtask

   task automatic model_clear();
      m_bubble = 0; m_waiting = 0; m_stall_cnt = 0; m_flush_cnt = 0;
      m_run = 0; m_err = 0;
   endtask

   task automatic set_idle();
      Rs1D = '0; Rs2D = '0; RdE = '0;
      MemReadE = 0; PCSrcE = 0; MemReqM = 0; MemReadyM = 0;
   endtask

   task automatic reset_dut();
      set_idle();
      @(negedge clk);
      reset_n = 0;
      #2;
      check("rst_state", 32'(CtrlState), 0);
      check("rst_stallcnt", 32'(StallCount), 0);
      check("rst_flushcnt", 32'(FlushCount), 0);
      check("rst_memerr", 32'(MemErr), 0);
      @(negedge clk);
      reset_n = 1;
      model_clear();
      @(posedge clk);
      #1;
   endtask

   // One clock cycle: drive inputs, compare all outputs before the edge,
   // then advance the model across the edge. Called at posedge+1.
   task automatic step(input logic [REG_W-1:0] rs1, input logic [REG_W-1:0] rs2,
                       input logic [REG_W-1:0] rd, input logic mr, input logic pc,
                       input logic req, input logic rdy);
      int mw, lu, e_sf, e_se, e_fd, e_ce, e_st;
      Rs1D = rs1; Rs2D = rs2; RdE = rd; MemReadE = mr; PCSrcE = pc;
      MemReqM = req; MemReadyM = rdy;
      mw = (req && !rdy) ? 1 : 0;
      lu = (mr && rd != 0 && (rd == rs1 || rd == rs2) && !m_bubble) ? 1 : 0;
      e_sf = (mw || (!pc && lu)) ? 1 : 0;
      e_se = mw;
      e_fd = (!mw && pc) ? 1 : 0;
      e_ce = (!mw && (pc || lu)) ? 1 : 0;
      e_st = m_waiting ? 2 : (m_bubble ? 1 : 0);
      #2;
      check("StallF", 32'(StallF), 32'(e_sf));
      check("StallD", 32'(StallD), 32'(e_sf));
      check("StallE", 32'(StallE), 32'(e_se));
      check("StallM", 32'(StallM), 32'(e_se));
      check("FlushD", 32'(FlushD), 32'(e_fd));
      check("ClearE", 32'(ClearE), 32'(e_ce));
      check("CtrlState", 32'(CtrlState), 32'(e_st));
      check("StallCount", 32'(StallCount), 32'(m_stall_cnt));
      check("FlushCount", 32'(FlushCount), 32'(m_flush_cnt));
      check("MemErr", 32'(MemErr), 32'(m_err));
      @(posedge clk);
      if (e_sf && m_stall_cnt < SAT) m_stall_cnt++;
      if (e_fd && m_flush_cnt < SAT) m_flush_cnt++;
      m_run = mw ? m_run + 1 : 0;
      if (m_run >= TIMEOUT) m_err = 1;
      m_waiting = mw;
      m_bubble  = (!mw && !pc && lu) ? 1 : 0;
      #1;
   endtask

   initial begin
      reset_n = 1;
      set_idle();
      model_clear();
      #1;
      reset_dut();

      // Load-use on Rs2, then masked repeat while the bubble is in EX.
      step(0, 5, 5, 1, 0, 0, 0);
      check("lu_state_bubble", 32'(CtrlState), 1);
      step(0, 5, 5, 1, 0, 0, 0);
      check("lu_state_run", 32'(CtrlState), 0);
      check("lu_stallcnt", 32'(StallCount), 1);

      // Load to x0 never stalls.
      step(0, 3, 0, 1, 0, 0, 0);
      check("x0_state", 32'(CtrlState), 0);
      check("x0_stallcnt", 32'(StallCount), 1);

      // Taken branch, then branch together with load-use.
      reset_dut();
      step(0, 0, 0, 0, 1, 0, 0);
      check("br_flushcnt", 32'(FlushCount), 1);
      step(7, 0, 7, 1, 1, 0, 0);
      check("brlu_stallcnt", 32'(StallCount), 0);
      check("brlu_flushcnt", 32'(FlushCount), 2);
      check("brlu_state", 32'(CtrlState), 0);

      // Memory wait with a pending branch.
      reset_dut();
      repeat (3) step(0, 0, 0, 0, 1, 1, 0);
      check("mw_state", 32'(CtrlState), 2);
      check("mw_stallcnt", 32'(StallCount), 3);
      check("mw_flushcnt", 32'(FlushCount), 0);
      step(0, 0, 0, 0, 1, 1, 1);
      check("mw_rel_flushcnt", 32'(FlushCount), 1);
      check("mw_rel_state", 32'(CtrlState), 0);

      // Timeout: sets after the fourth wait cycle and stays set.
      reset_dut();
      repeat (3) step(0, 0, 0, 0, 0, 1, 0);
      check("to_before", 32'(MemErr), 0);
      step(0, 0, 0, 0, 0, 1, 0);
      check("to_set", 32'(MemErr), 1);
      repeat (2) step(0, 0, 0, 0, 0, 1, 0);
      step(0, 0, 0, 0, 0, 1, 1);
      check("to_sticky", 32'(MemErr), 1);
      step(0, 0, 0, 0, 0, 0, 0);
      check("to_sticky2", 32'(MemErr), 1);

      // Asynchronous reset mid-wait, between clock edges.
      repeat (5) step(0, 0, 0, 0, 0, 1, 0);
      check("ar_pre_state", 32'(CtrlState), 2);
      #2;
      reset_n = 0;
      #1;
      check("ar_state", 32'(CtrlState), 0);
      check("ar_stallcnt", 32'(StallCount), 0);
      check("ar_memerr", 32'(MemErr), 0);
      set_idle();
      #1;
      check("ar_stallf_idle", 32'(StallF), 0);
      check("ar_stallm_idle", 32'(StallM), 0);
      @(negedge clk);
      reset_n = 1;
      model_clear();
      @(posedge clk);
      #1;
      step(0, 0, 0, 0, 0, 0, 0);

      // Randomized traffic; small register range makes hazards frequent.
      for (int i = 0; i < 600; i++) begin
         step(REG_W'($urandom_range(0, 3)), REG_W'($urandom_range(0, 3)),
              REG_W'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
              1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 2) != 0),
              1'($urandom_range(0, 2) == 0));
      end
      check("rand_stall_saturated", 32'(StallCount), 32'(SAT));

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/hazard_ctrl.md
# hazard_ctrl

Pipeline hazard controller for the five-stage RV32I core. It sequences the stall and clear controls of the PC, IF/ID, ID/EX and EX/MEM registers. It inserts a one-cycle bubble on load-use hazards, flushes wrong-path instructions on a taken branch or jump, and freezes the pipeline while the data memory is not ready. Saturating stall/flush statistics and a sticky memory-timeout flag are kept for debug.

## Interface
- REG_W, 5, register-index width
- CNT_W, 16, statistics counter width
- TIMEOUT, 255, memory-wait cycles before MemErr sets (1..2^CNT_W-1)

- clk  in  1  rising-edge clock
- reset_n  in  1  asynchronous, active-low reset
- Rs1D, Rs2D  in  REG_W  source registers of the instruction in ID
- RdE  in  REG_W  destination of the instruction in EX
- MemReadE  in  1  instruction in EX is a load
- PCSrcE  in  1  branch/jump taken, resolved in EX
- MemReqM  in  1  load/store in MEM is accessing data memory
- MemReadyM  in  1  data memory completes the access this cycle
- StallF, StallD  out  1  hold PC / IF/ID
- StallE, StallM  out  1  hold ID/EX / EX/MEM
- FlushD  out  1  clear IF/ID
- ClearE  out  1  drives the clear input of the ID/EX register
- CtrlState  out  2  RUN=0, LOAD_BUBBLE=1, MEM_WAIT=2
- StallCount  out  CNT_W  cycles with StallF=1, saturating
- FlushCount  out  CNT_W  cycles with FlushD=1, saturating
- MemErr  out  1  sticky: a memory wait reached TIMEOUT

## Operation
Condition terms:
- **MemWait** = MemReqM & ~MemReadyM.
- **LoadUse** = MemReadE & (RdE != 0) & (RdE == Rs1D | RdE == Rs2D). It is masked to 0 in LOAD_BUBBLE.

Output priority is evaluated every cycle in every state:
1. **MemWait:** StallF = StallD = StallE = StallM = 1. FlushD = ClearE = 0, even if PCSrcE = 1; the branch stays in EX and is re-evaluated.
2. **PCSrcE:** FlushD = 1 and ClearE = 1. Stalls are 0. This overrides LoadUse.
3. **LoadUse:** StallF = StallD = 1 and ClearE = 1. StallE, StallM and FlushD are 0.
4. **Otherwise:** all control outputs are 0.

State machine (next state follows the same priority):
- **RUN:**
  - MemWait → MEM_WAIT
  - PCSrcE → RUN
  - LoadUse → LOAD_BUBBLE
  - otherwise → RUN
- **LOAD_BUBBLE:** lasts one cycle while the bubble is in EX.
  - MemWait → MEM_WAIT
  - otherwise → RUN
- **MEM_WAIT:**
  - While MemWait, remain in MEM_WAIT.
  - When MemReadyM = 1 (or MemReqM drops), outputs and next state are computed exactly as in RUN with MemWait = 0.

Wait counter (internal, CNT_W bits):
- Cleared whenever the next state is not MEM_WAIT.
- Increments each cycle spent in MEM_WAIT with MemWait = 1.
- When it reaches TIMEOUT, MemErr is set. MemErr stays 1 until reset; the FSM keeps waiting.

Statistics:
- StallCount increments on each edge where StallF = 1.
- FlushCount increments on each edge where FlushD = 1.
- Both saturate at 2^CNT_W − 1 and never wrap.

## Timing
- All control outputs are combinational (Mealy) from the state and current inputs. Hazard-to-control latency is zero cycles.
- State, counters and MemErr update on the rising edge of clk.
- A load-use hazard costs exactly one stall cycle; a taken branch costs two flushed slots (ID and EX).
- A memory wait of N cycles with MemReadyM low holds all stages for N cycles. The pipeline advances in the cycle MemReadyM rises.
- Reset (reset_n = 0, asynchronous, at any point including mid-MEM_WAIT):
  - State → RUN; CtrlState = 0.
  - StallCount = FlushCount = 0; wait counter = 0; MemErr = 0.
  - With inputs idle, all control outputs are 0.
  - Normal operation resumes on the first rising edge after reset_n goes high.

## Test plan
- **Load-use:** MemReadE = 1, RdE = 5, Rs2D = 5 → one cycle with StallF = StallD = ClearE = 1, then CtrlState = 1 with all controls 0, then RUN. StallCount = 1.
- **x0 destination:** RdE = 0 with Rs1D = 0 and MemReadE = 1 → no stall; CtrlState stays 0.
- **Taken branch:** PCSrcE = 1 → FlushD = ClearE = 1 for that cycle only. FlushCount = 1. PCSrcE asserted together with LoadUse → flush only, no StallF.
- **Memory wait with branch:** MemReqM = 1, MemReadyM = 0 for 3 cycles, with PCSrcE = 1 throughout → all four stalls high and FlushD = 0 for 3 cycles. On the cycle MemReadyM = 1: stalls drop, FlushD = ClearE = 1. StallCount = 3.
- **Timeout:** TIMEOUT = 4, MemReadyM held low for 6 cycles → MemErr = 1 after the 4th wait cycle. It remains 1 after MemReadyM rises, until reset_n pulses low.
- **Async reset:** reset_n pulsed low mid-MEM_WAIT, between clock edges → CtrlState = 0, counters = 0, MemErr = 0 immediately. With inputs idle, stalls drop.
